// File: rtl/mac_load_seq_if.sv
// mac_load_seq_if: control/command bundle between a run controller and the weight-load sequencer
// Signals:
//   start      controller -> seq  one-cycle run request
//   hold       controller -> seq  stall, freezes the sequencer
//   load       seq -> controller  3'b001 lower-half load, 3'b010 upper-half load
//   in_load_en seq -> controller  input-memory address advance pulse
//   mac_en     seq -> controller  compute enable
//   half_sel   seq -> controller  0 lower half, 1 upper half
//   layer_idx  seq -> controller  current weight line
//   busy       seq -> controller  run in progress
//   done       seq -> controller  end-of-run pulse
//   stall_cnt  seq -> controller  stalled-cycle count (only with SEQ_PERF_CNT_EN)
interface mac_load_seq_if #(
  parameter int LAYER_W = 8
);
  logic start;
  logic hold;
  logic [2:0] load;
  logic in_load_en;
  logic mac_en;
  logic half_sel;
  logic [LAYER_W-1:0] layer_idx;
  logic busy;
  logic done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  modport master (
    output start, hold,
    input  load, in_load_en, mac_en, half_sel, layer_idx, busy, done, stall_cnt
  );
  modport slave (
    input  start, hold,
    output load, in_load_en, mac_en, half_sel, layer_idx, busy, done, stall_cnt
  );
`else
  modport master (
    output start, hold,
    input  load, in_load_en, mac_en, half_sel, layer_idx, busy, done
  );
  modport slave (
    input  start, hold,
    output load, in_load_en, mac_en, half_sel, layer_idx, busy, done
  );
`endif
endinterface

// File: rtl/mac_load_seq.sv
// mac_load_seq: sequences weight-half loads and MAC compute windows over N_LAYERS weight lines
// Ports:
//   clk    single clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    mac_load_seq_if.slave (start/hold in; load, in_load_en, mac_en, half_sel,
//          layer_idx, busy, done out; stall_cnt out when enabled)
// Optional feature: define SEQ_PERF_CNT_EN to add the saturating stall_cnt counter.
module mac_load_seq #(
  parameter int N_LAYERS    = 256,
  parameter int COMP_CYCLES = 4,
  parameter int LAYER_W     = $clog2(N_LAYERS)
) (
  input logic clk,
  input logic rst_n,
  mac_load_seq_if.slave bus
);
  localparam int CNT_W = $clog2(COMP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMP_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(N_LAYERS - 1);
  typedef enum logic [2:0] {IDLE, LOAD_LO, COMP_LO, LOAD_HI, COMP_HI, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic cnt_last;
  logic layer_last;
  assign cnt_last   = cyc_cnt_q == CNT_LAST;
  assign layer_last = layer_q == LAYER_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      layer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      layer_q   <= layer_d;
    end
  end
  // hold freezes state and both counters; the LOAD states clear cyc_cnt so each
  // COMP state is entered with a fresh count.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    layer_d   = layer_q;
    if (!bus.hold) begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_d = LOAD_LO;
          layer_d = '0;
        end
        LOAD_LO: begin
          state_d   = COMP_LO;
          cyc_cnt_d = '0;
        end
        COMP_LO: if (cnt_last) state_d = LOAD_HI;
          else cyc_cnt_d = cyc_cnt_q + 1'b1;
        LOAD_HI: begin
          state_d   = COMP_HI;
          cyc_cnt_d = '0;
        end
        COMP_HI: if (cnt_last) begin
          if (layer_last) state_d = DONE;
          else state_d = LOAD_LO;
          layer_d = layer_last ? '0 : layer_q + 1'b1;
        end else cyc_cnt_d = cyc_cnt_q + 1'b1;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // Command pulses are masked during hold so a frozen state never repeats them.
  assign bus.load       = bus.hold ? 3'b000 :
                          state_q == LOAD_LO ? 3'b001 :
                          state_q == LOAD_HI ? 3'b010 : 3'b000;
  assign bus.in_load_en = !bus.hold && state_q == COMP_HI && cnt_last;
  assign bus.mac_en     = !bus.hold && (state_q == COMP_LO || state_q == COMP_HI);
  assign bus.half_sel   = state_q == COMP_HI;
  assign bus.layer_idx  = layer_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = !bus.hold && state_q == DONE;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start && !bus.hold) stall_d = '0;
    else if (state_q != IDLE && bus.hold && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mac_load_seq.sv
// tb_mac_load_seq: randomized and directed self-check of mac_load_seq against an expected-command queue
module tb_mac_load_seq;
  localparam int NL = 2;
  localparam int CC = 3;
  localparam int LW = $clog2(NL);
  localparam int VW = 3 + 1 + 1 + 1 + LW + 1 + 1;
  localparam logic [VW-1:0] GATE = {3'b111, 1'b1, 1'b1, 1'b0, {LW{1'b0}}, 1'b0, 1'b1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mac_load_seq_if #(.LAYER_W(LW)) bus();
  mac_load_seq #(.N_LAYERS(NL), .COMP_CYCLES(CC), .LAYER_W(LW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  logic [VW-1:0] q[$];
  logic [VW-1:0] act_v, exp_v;
  int compared = 0;
  int mismatched = 0;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_m = 0;
  logic [31:0] act_stall, exp_stall;
`endif
  function automatic logic [VW-1:0] pk(input logic [2:0] ld, input logic ile, input logic mac,
                                       input logic half, input int idx, input logic busy,
                                       input logic done);
    return {ld, ile, mac, half, LW'(idx), busy, done};
  endfunction
  // One entry per unstalled cycle of a full run, built straight from the layer schedule.
  task automatic push_run();
    for (int l = 0; l < NL; l++) begin
      q.push_back(pk(3'b001, 0, 0, 0, l, 1, 0));
      for (int c = 0; c < CC; c++) q.push_back(pk(3'b000, 0, 1, 0, l, 1, 0));
      q.push_back(pk(3'b010, 0, 0, 0, l, 1, 0));
      for (int c = 0; c < CC; c++) q.push_back(pk(3'b000, c == CC - 1, 1, 1, l, 1, 0));
    end
    q.push_back(pk(3'b000, 0, 0, 0, 0, 1, 1));
  endtask
  function automatic logic [VW-1:0] expv(input logic h);
    logic [VW-1:0] e;
    e = q.size() == 0 ? '0 : q[0];
    if (h) e = e & ~GATE;
    return e;
  endfunction
  task automatic step_model(input logic s, input logic h);
    if (q.size() != 0) begin
      if (h) begin
`ifdef SEQ_PERF_CNT_EN
        if (stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
`endif
      end else void'(q.pop_front());
    end else if (s && !h) begin
      push_run();
`ifdef SEQ_PERF_CNT_EN
      stall_m = 0;
`endif
    end
  endtask
  // Drives one cycle, snapshots DUT and model mid-cycle, then advances the model on the edge.
  task automatic cyc(input logic s, input logic h);
    bus.start = s;
    bus.hold  = h;
    @(negedge clk);
    exp_v = expv(h);
    act_v = {bus.load, bus.in_load_en, bus.mac_en, bus.half_sel, bus.layer_idx, bus.busy, bus.done};
`ifdef SEQ_PERF_CNT_EN
    act_stall = bus.stall_cnt;
    exp_stall = stall_m;
`endif
    @(posedge clk);
    step_model(s, h);
    #1;
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    act_v = {bus.load, bus.in_load_en, bus.mac_en, bus.half_sel, bus.layer_idx, bus.busy, bus.done};
    compared++;
    if (act_v !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", act_v, {VW{1'b0}});
    end
    rst_n = 1'b1;
  endtask
  task automatic test_nominal();
    int done_at = -1;
    int busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(k == 0, 1'b0);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL nominal cyc %0d: got %h want %h", k, act_v, exp_v);
      end
      if (act_v[0]) done_at = k;
      if (act_v[1]) busy_n++;
    end
    compared++;
    if (done_at !== 17) begin
      mismatched++;
      $display("FAIL nominal_done_cycle: got %0d want 17", done_at);
    end
    compared++;
    if (busy_n !== 17) begin
      mismatched++;
      $display("FAIL nominal_busy_cycles: got %0d want 17", busy_n);
    end
  endtask
  task automatic test_hold();
    int done_at = -1;
    logic [2:0] ld8;
    for (int k = 0; k < 23; k++) begin
      cyc(k == 0, k >= 5 && k <= 7);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL hold cyc %0d: got %h want %h", k, act_v, exp_v);
      end
      if (act_v[0]) done_at = k;
      if (k == 8) ld8 = act_v[VW-1 -: 3];
    end
    compared++;
    if (ld8 !== 3'b010) begin
      mismatched++;
      $display("FAIL hold_load_hi_cycle8: got %b want 010", ld8);
    end
    compared++;
    if (done_at !== 20) begin
      mismatched++;
      $display("FAIL hold_done_cycle: got %0d want 20", done_at);
    end
`ifdef SEQ_PERF_CNT_EN
    compared++;
    if (act_stall !== 32'd3) begin
      mismatched++;
      $display("FAIL stall_after_done: got %0d want 3", act_stall);
    end
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 19; k++) begin
      cyc(1'b0, 1'b0);
      if (k == 0) begin
        compared++;
        if (act_stall !== 32'd0) begin
          mismatched++;
          $display("FAIL stall_clear_on_start: got %0d want 0", act_stall);
        end
      end
    end
`endif
  endtask
  task automatic test_restart();
    int dones = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(k == 0 || k == 6, 1'b0);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL restart cyc %0d: got %h want %h", k, act_v, exp_v);
      end
      if (act_v[0]) dones++;
    end
    compared++;
    if (dones !== 1) begin
      mismatched++;
      $display("FAIL restart_done_count: got %0d want 1", dones);
    end
  endtask
  task automatic test_midrun_reset();
    int dones = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(k == 0, 1'b0);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL midrst cyc %0d: got %h want %h", k, act_v, exp_v);
      end
    end
    rst_n = 1'b0;
    #1;
    act_v = {bus.load, bus.in_load_en, bus.mac_en, bus.half_sel, bus.layer_idx, bus.busy, bus.done};
    compared++;
    if (act_v !== '0) begin
      mismatched++;
      $display("FAIL midrst_async: got %h want %h", act_v, {VW{1'b0}});
    end
    q.delete();
`ifdef SEQ_PERF_CNT_EN
    stall_m = 0;
`endif
    for (int k = 10; k < 35; k++) begin
      if (k == 14) rst_n = 1'b1;
      cyc(k == 15, 1'b0);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL midrst cyc %0d: got %h want %h", k, act_v, exp_v);
      end
      if (act_v[0] && k < 16) dones++;
      if (k == 16) begin
        compared++;
        if (act_v[VW-1 -: 3] !== 3'b001 || act_v[2 +: LW] !== '0) begin
          mismatched++;
          $display("FAIL midrst_restart: got load %b idx %0d want load 001 idx 0",
                   act_v[VW-1 -: 3], act_v[2 +: LW]);
        end
      end
    end
    compared++;
    if (dones !== 0) begin
      mismatched++;
      $display("FAIL midrst_no_done: got %0d want 0", dones);
    end
  endtask
  task automatic test_start_hold_idle();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    compared++;
    if (act_v !== exp_v || act_v[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL start_hold_idle: got %h want %h", act_v, exp_v);
    end
  endtask
  task automatic test_random();
    logic s, h;
    for (int k = 0; k < 1200; k++) begin
      s = $urandom_range(0, 5) == 0;
      h = $urandom_range(0, 3) == 0;
      cyc(s, h);
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL random cyc %0d: got %h want %h", k, act_v, exp_v);
      end
`ifdef SEQ_PERF_CNT_EN
      compared++;
      if (act_stall !== exp_stall) begin
        mismatched++;
        $display("FAIL random_stall cyc %0d: got %0d want %0d", k, act_stall, exp_stall);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_restart();
    test_midrun_reset();
    test_start_hold_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
